awb_gain_ctrl: RTL



---
 rtl/awb_pkg.sv | 21 ++
 rtl/awb_seq_div.sv | 75 +++++++
 rtl/awb_gain_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/awb_pkg.sv
// rtl/awb_pkg.sv - shared state encoding and gain helpers for the AWB gain controller
package awb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DIV_R,
      DIV_B,
      SMOOTH
   } awb_state_t;

   // Unity gain in unsigned fixed point with frac fractional bits
   function automatic int unsigned unity(input int unsigned frac);
      return 32'd1 << frac;
   endfunction

   // Saturate a raw quotient to the gain ceiling
   function automatic logic [31:0] clamp_gain(input logic [31:0] value, input logic [31:0] ceiling);
      return (value > ceiling) ? ceiling : value;
   endfunction

endpackage

// File: rtl/awb_seq_div.sv
// rtl/awb_seq_div.sv - restoring sequential divider, one quotient bit per cycle
module awb_seq_div #(
   parameter int DW = 10,
   parameter int QW = 18
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [QW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [QW-1:0] quotient,
   output logic          div_by_zero
);

   localparam int CW = $clog2(QW + 1);

   logic [DW-1:0] rem_q;
   logic [DW-1:0] dsr_q;
   logic [CW-1:0] cnt_q;
   logic          load;
   logic [DW-1:0] step_rem;
   logic [DW-1:0] step_dsr;
   logic [QW-1:0] step_quo;
   logic [DW:0]   trial;
   logic          ge;
   logic [DW-1:0] rem_nx;
   logic [QW-1:0] quo_nx;

   assign load = start && !busy;

   // One restoring step; the first step runs on the start edge straight from the operands
   always_comb begin
      step_rem = load ? '0 : rem_q;
      step_quo = load ? dividend : quotient;
      step_dsr = load ? divisor : dsr_q;
      trial    = {step_rem, step_quo[QW-1]};
      ge       = (trial >= {1'b0, step_dsr});
      rem_nx   = ge ? DW'(trial - {1'b0, step_dsr}) : trial[DW-1:0];
      quo_nx   = {step_quo[QW-2:0], ge};
   end

   // Iteration counter, partial remainder/quotient shift register and done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_q       <= '0;
         dsr_q       <= '0;
         cnt_q       <= '0;
         quotient    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            rem_q       <= rem_nx;
            quotient    <= quo_nx;
            dsr_q       <= divisor;
            div_by_zero <= (divisor == '0);
            cnt_q       <= CW'(QW - 1);
            busy        <= 1'b1;
         end else if (busy) begin
            rem_q    <= rem_nx;
            quotient <= quo_nx;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/awb_gain_ctrl.sv
// rtl/awb_gain_ctrl.sv - AWB gain controller top; AWB_DROP_CNT_EN adds the drop_cnt output
module awb_gain_ctrl
   import awb_pkg::*;
#(
   parameter int AVG_BITS     = 10,
   parameter int GAIN_FRAC    = 8,
   parameter int GAIN_BITS    = 12,
   parameter int GAIN_MAX     = 4095,
   parameter int SMOOTH_SHIFT = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 avg_valid,
   input  logic [AVG_BITS-1:0]  ch0_avg,
   input  logic [AVG_BITS-1:0]  ch1_avg,
   input  logic [AVG_BITS-1:0]  ch2_avg,
   input  logic [AVG_BITS-1:0]  ch3_avg,
   output logic [GAIN_BITS-1:0] gain_r,
   output logic [GAIN_BITS-1:0] gain_g,
   output logic [GAIN_BITS-1:0] gain_b,
   output logic                 gain_valid,
`ifdef AWB_DROP_CNT_EN
   output logic [15:0]          drop_cnt,
`endif
   output logic                 busy
);

   localparam int QBITS = AVG_BITS + GAIN_FRAC;
   localparam logic [GAIN_BITS-1:0] UNITY = GAIN_BITS'(unity(GAIN_FRAC));
   localparam logic [GAIN_BITS-1:0] GMAX  = GAIN_BITS'(GAIN_MAX);

   awb_state_t state, state_nx;

   logic [AVG_BITS-1:0]  r_q, g_q, b_q;
   logic [AVG_BITS:0]    g_sum;
   logic                 capture;
   logic                 div_start, div_busy, div_done, div_dbz;
   logic [AVG_BITS-1:0]  div_divisor;
   logic [QBITS-1:0]     div_quot;
   logic [GAIN_BITS-1:0] div_tgt, tgt_r, tgt_b, new_r, new_b;
   logic signed [GAIN_BITS:0] diff_r, diff_b, step_r, step_b;

   assign gain_g  = UNITY;
   assign busy    = (state != IDLE);
   assign g_sum   = {1'b0, ch1_avg} + {1'b0, ch2_avg};
   assign capture = (state == IDLE) && avg_valid && enable;
   assign div_tgt = div_dbz ? GMAX : GAIN_BITS'(clamp_gain(32'(div_quot), 32'(GAIN_MAX)));

   awb_seq_div #(
      .DW (AVG_BITS),
      .QW (QBITS)
   ) u_div (
      .clk         (clk),
      .reset       (reset),
      .start       (div_start),
      .dividend    ({g_q, GAIN_FRAC'(0)}),
      .divisor     (div_divisor),
      .busy        (div_busy),
      .done        (div_done),
      .quotient    (div_quot),
      .div_by_zero (div_dbz)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next state and divider control; the blue divide is launched on the red done cycle
   always_comb begin
      state_nx    = state;
      div_start   = 1'b0;
      div_divisor = r_q;
      case (state)
         IDLE:   if (capture) state_nx = DIV_R;
         DIV_R: begin
            div_start = !div_busy;
            if (div_done) begin
               div_divisor = b_q;
               state_nx    = DIV_B;
            end
         end
         DIV_B:  if (div_done) state_nx = SMOOTH;
         SMOOTH: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // First-order IIR step toward the target; the arithmetic shift never overshoots
   always_comb begin
      diff_r = $signed({1'b0, tgt_r}) - $signed({1'b0, gain_r});
      diff_b = $signed({1'b0, tgt_b}) - $signed({1'b0, gain_b});
      step_r = diff_r >>> SMOOTH_SHIFT;
      step_b = diff_b >>> SMOOTH_SHIFT;
      new_r  = gain_r + step_r[GAIN_BITS-1:0];
      new_b  = gain_b + step_b[GAIN_BITS-1:0];
   end

   // Stats capture, target latching and gain update with its valid pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q        <= '0;
         g_q        <= '0;
         b_q        <= '0;
         tgt_r      <= UNITY;
         tgt_b      <= UNITY;
         gain_r     <= UNITY;
         gain_b     <= UNITY;
         gain_valid <= 1'b0;
      end else begin
         gain_valid <= 1'b0;
         if (capture) begin
            r_q <= ch0_avg;
            b_q <= ch3_avg;
            g_q <= g_sum[AVG_BITS:1];
         end
         if (state == DIV_R && div_done) tgt_r <= div_tgt;
         if (state == DIV_B && div_done) tgt_b <= div_tgt;
         if (state == SMOOTH) begin
            gain_r     <= new_r;
            gain_b     <= new_b;
            gain_valid <= 1'b1;
         end
      end
   end

`ifdef AWB_DROP_CNT_EN
   // Saturating count of enabled strobes that arrive while a calculation is running
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         drop_cnt <= '0;
      else if (avg_valid && enable && busy && drop_cnt != 16'hFFFF)
         drop_cnt <= drop_cnt + 16'd1;
   end
`endif

endmodule
